color_size_tx: RTL and testbench

Serial transmitter for the color/size link, on the vision-side board, driving the three-wire bus that the navigation board's color/size receiver samples on its RCLK/RDATA/RESET pins. It accepts a 4-bit COLOR code and a 4-bit SIZE code with a one-cycle SEND strobe and emits one framed, clock-forwarded serial word. BUSY and DONE flags handshake with the classifier logic.

---
 rtl/color_size_tx.sv | 159 +++++++++++++++
 tb/tb_color_size_tx.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/color_size_tx.sv
// Clock-forwarded serial transmitter for the color/size link: SYNC, then 8 (or 9) MSB-first bits, then GAP.
// Optional even-parity bit after COLOR[0] is enabled by defining COLOR_SIZE_TX_PARITY_EN.
module color_size_tx #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       SEND,
    input  logic [3:0] COLOR_IN,
    input  logic [3:0] SIZE_IN,
    output logic       TCLK,
    output logic       TDATA,
    output logic       TRESET,
    output logic       BUSY,
    output logic       DONE
);

`ifdef COLOR_SIZE_TX_PARITY_EN
    localparam int NBITS = 9;
`else
    localparam int NBITS = 8;
`endif

    localparam logic [15:0] HALF_LAST = 16'(CLK_DIV - 1);
    localparam logic [3:0]  LAST_BIT  = 4'(NBITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        SHIFT = 2'd2,
        GAP   = 2'd3
    } state_t;

    state_t             state;
    logic [15:0]        phase;
    logic               half;
    logic [3:0]         bit_cnt;
    logic [NBITS-1:0]   shreg;
    logic               half_end;

`ifdef COLOR_SIZE_TX_PARITY_EN
    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction

    function automatic logic [NBITS-1:0] load_word(input logic [3:0] s, input logic [3:0] c);
        return {s, c, even_parity({s, c})};
    endfunction
`else
    function automatic logic [NBITS-1:0] load_word(input logic [3:0] s, input logic [3:0] c);
        return {s, c};
    endfunction
`endif

    // Phase counter measures half bit periods; 'half' selects the low or high half.
    assign half_end = (phase == HALF_LAST);

    // Frame sequencer with registered bus outputs.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state   <= IDLE;
            phase   <= 16'd0;
            half    <= 1'b0;
            bit_cnt <= 4'd0;
            shreg   <= '0;
            TCLK    <= 1'b0;
            TDATA   <= 1'b0;
            TRESET  <= 1'b0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    DONE    <= 1'b0;
                    TCLK    <= 1'b0;
                    TDATA   <= 1'b0;
                    phase   <= 16'd0;
                    half    <= 1'b0;
                    bit_cnt <= 4'd0;
                    if (SEND) begin
                        shreg  <= load_word(SIZE_IN, COLOR_IN);
                        state  <= SYNC;
                        BUSY   <= 1'b1;
                        TRESET <= 1'b1;
                    end else begin
                        BUSY   <= 1'b0;
                        TRESET <= 1'b0;
                    end
                end
                SYNC: begin
                    if (half_end) begin
                        phase <= 16'd0;
                        if (half) begin
                            half   <= 1'b0;
                            state  <= SHIFT;
                            TRESET <= 1'b0;
                            TDATA  <= shreg[NBITS-1];
                        end else begin
                            half <= 1'b1;
                        end
                    end else begin
                        phase <= phase + 16'd1;
                    end
                end
                SHIFT: begin
                    if (half_end) begin
                        phase <= 16'd0;
                        if (!half) begin
                            half <= 1'b1;
                            TCLK <= 1'b1;
                        end else begin
                            half <= 1'b0;
                            TCLK <= 1'b0;
                            // TDATA only moves on the falling TCLK edge.
                            if (bit_cnt == LAST_BIT) begin
                                state   <= GAP;
                                TDATA   <= 1'b0;
                                bit_cnt <= 4'd0;
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                                shreg   <= {shreg[NBITS-2:0], 1'b0};
                                TDATA   <= shreg[NBITS-2];
                            end
                        end
                    end else begin
                        phase <= phase + 16'd1;
                    end
                end
                GAP: begin
                    if (half_end) begin
                        phase <= 16'd0;
                        if (half) begin
                            half  <= 1'b0;
                            state <= IDLE;
                            BUSY  <= 1'b0;
                            DONE  <= 1'b1;
                        end else begin
                            half <= 1'b1;
                        end
                    end else begin
                        phase <= phase + 16'd1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    phase   <= 16'd0;
                    half    <= 1'b0;
                    bit_cnt <= 4'd0;
                    TCLK    <= 1'b0;
                    TDATA   <= 1'b0;
                    TRESET  <= 1'b0;
                    BUSY    <= 1'b0;
                    DONE    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_color_size_tx.sv
// Directed self-checking bench for color_size_tx; a negedge monitor records sampled bits and flag counts.
module tb_color_size_tx;

    localparam int D = 2;
`ifdef COLOR_SIZE_TX_PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif
    localparam int FRAME = (NB + 2) * 2 * D;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       SEND;
    logic [3:0] COLOR_IN;
    logic [3:0] SIZE_IN;
    logic       TCLK, TDATA, TRESET, BUSY, DONE;

    int checks = 0;
    int errors = 0;

    logic bits_q[$];
    int   busy_total = 0, treset_total = 0, done_total = 0;
    int   tdata_glitch = 0, done_busy = 0;
    logic prev_tclk = 1'b0, prev_tdata = 1'b0;

    color_size_tx #(.CLK_DIV(D)) dut (
        .CLK(CLK), .RESET(RESET), .SEND(SEND), .COLOR_IN(COLOR_IN), .SIZE_IN(SIZE_IN),
        .TCLK(TCLK), .TDATA(TDATA), .TRESET(TRESET), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    // Receiver-side view: sample TDATA at each TCLK rise, count flag cycles.
    always @(negedge CLK) begin
        if (TCLK === 1'b1 && prev_tclk === 1'b0) bits_q.push_back(TDATA);
        if (TCLK === 1'b1 && prev_tclk === 1'b1 && TDATA !== prev_tdata) tdata_glitch++;
        if (BUSY === 1'b1) busy_total++;
        if (TRESET === 1'b1) treset_total++;
        if (DONE === 1'b1) begin
            done_total++;
            if (BUSY !== 1'b0) done_busy++;
        end
        prev_tclk  = TCLK;
        prev_tdata = TDATA;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic pulse_send(input logic [3:0] c, input logic [3:0] s);
        @(negedge CLK);
        COLOR_IN = c;
        SIZE_IN  = s;
        SEND     = 1'b1;
        @(negedge CLK);
        SEND = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge CLK);
            if (DONE === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [7:0] get_byte(input int start);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[7-i] = (bits_q.size() > start + i) ? bits_q[start+i] : 1'bx;
        return b;
    endfunction

    task automatic test_reset();
        RESET = 1'b1; SEND = 1'b1; COLOR_IN = 4'd4; SIZE_IN = 4'd1;
        repeat (3) @(negedge CLK);
        checks++;
        if ({TCLK, TDATA, TRESET, BUSY, DONE} !== 5'b0) begin
            errors++; $display("FAIL reset_outputs: got %b expected 00000", {TCLK, TDATA, TRESET, BUSY, DONE});
        end
        RESET = 1'b0; SEND = 1'b0;
        repeat (4) @(negedge CLK);
        checks++;
        if (busy_total !== 0 || treset_total !== 0) begin
            errors++; $display("FAIL reset_send_held: busy cycles %0d treset cycles %0d expected 0 0", busy_total, treset_total);
        end
        pulse_send(4'd2, 4'd2);
        repeat (14) @(negedge CLK);
        checks++;
        if (BUSY !== 1'b1) begin
            errors++; $display("FAIL reset_prebusy: BUSY got %b expected 1", BUSY);
        end
        @(posedge CLK);
        #2 RESET = 1'b1;
        #1;
        checks++;
        if ({TCLK, TDATA, TRESET, BUSY, DONE} !== 5'b0) begin
            errors++; $display("FAIL reset_async: got %b expected 00000", {TCLK, TDATA, TRESET, BUSY, DONE});
        end
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    task automatic test_basic();
        int b0, bz, tr, dn, cnt;
        bit ok;
        b0 = bits_q.size(); bz = busy_total; tr = treset_total; dn = done_total;
        pulse_send(4'd4, 4'd1);
        checks++;
        if ({BUSY, TRESET} !== 2'b11) begin
            errors++; $display("FAIL basic_start: BUSY,TRESET got %b expected 11", {BUSY, TRESET});
        end
        cnt = 0;
        while (TCLK !== 1'b1 && cnt < 50) begin
            @(negedge CLK);
            cnt++;
        end
        checks++;
        if (cnt !== 3 * D) begin
            errors++; $display("FAIL basic_first_tclk: got %0d cycles expected %0d", cnt, 3 * D);
        end
        wait_done(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL basic_done_timeout: got no DONE expected DONE"); end
        checks++;
        if (get_byte(b0) !== 8'b0001_0100) begin
            errors++; $display("FAIL basic_bits: got %b expected 00010100", get_byte(b0));
        end
        checks++;
        if (bits_q.size() - b0 !== NB) begin
            errors++; $display("FAIL basic_bitcount: got %0d expected %0d", bits_q.size() - b0, NB);
        end
`ifdef COLOR_SIZE_TX_PARITY_EN
        checks++;
        if (bits_q[b0+8] !== 1'b0) begin
            errors++; $display("FAIL basic_parity: got %b expected 0", bits_q[b0+8]);
        end
`endif
        checks++;
        if (busy_total - bz !== FRAME) begin
            errors++; $display("FAIL basic_busy_len: got %0d expected %0d", busy_total - bz, FRAME);
        end
        checks++;
        if (treset_total - tr !== 2 * D) begin
            errors++; $display("FAIL basic_treset_len: got %0d expected %0d", treset_total - tr, 2 * D);
        end
        checks++;
        if (done_total - dn !== 1 || DONE !== 1'b0) begin
            errors++; $display("FAIL basic_done_pulse: got count %0d DONE now %b expected 1 0", done_total - dn, DONE);
        end
        checks++;
        if (done_busy !== 0 || tdata_glitch !== 0) begin
            errors++; $display("FAIL basic_protocol: got done_busy %0d glitch %0d expected 0 0", done_busy, tdata_glitch);
        end
    endtask

`ifdef COLOR_SIZE_TX_PARITY_EN
    task automatic test_parity();
        int b0, bz;
        bit ok;
        b0 = bits_q.size(); bz = busy_total;
        pulse_send(4'd3, 4'd1);
        wait_done(ok);
        checks++;
        if (!ok || get_byte(b0) !== 8'b0001_0011 || bits_q.size() - b0 !== 9 || bits_q[b0+8] !== 1'b1) begin
            errors++; $display("FAIL parity_bits: got %b size %0d expected 00010011 + 1", get_byte(b0), bits_q.size() - b0);
        end
        checks++;
        if (busy_total - bz !== 44) begin
            errors++; $display("FAIL parity_busy_len: got %0d expected 44", busy_total - bz);
        end
    endtask
`endif

    task automatic test_busy_reject();
        int b0, bz, dn;
        bit ok;
        b0 = bits_q.size(); bz = busy_total; dn = done_total;
        pulse_send(4'd0, 4'd2);
        repeat (9) @(negedge CLK);
        COLOR_IN = 4'd5;
        SEND = 1'b1;
        @(negedge CLK);
        SEND = 1'b0;
        wait_done(ok);
        repeat (30) @(negedge CLK);
        checks++;
        if (!ok || get_byte(b0) !== 8'b0010_0000) begin
            errors++; $display("FAIL reject_bits: got %b expected 00100000", get_byte(b0));
        end
        checks++;
        if (done_total - dn !== 1 || busy_total - bz !== FRAME) begin
            errors++; $display("FAIL reject_single: got done %0d busy %0d expected 1 %0d", done_total - dn, busy_total - bz, FRAME);
        end
    endtask

    task automatic test_back_to_back();
        int b0, bz, dn;
        bit seen, ok;
        b0 = bits_q.size(); bz = busy_total; dn = done_total;
        pulse_send(4'd3, 4'd0);
        repeat (5) @(negedge CLK);
        COLOR_IN = 4'd5; SIZE_IN = 4'd1; SEND = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge CLK);
            if (DONE === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        @(negedge CLK);
        checks++;
        if (!seen || {TRESET, BUSY, DONE} !== 3'b110) begin
            errors++; $display("FAIL b2b_restart: got TRESET,BUSY,DONE %b seen %b expected 110", {TRESET, BUSY, DONE}, seen);
        end
        SEND = 1'b0;
        wait_done(ok);
        checks++;
        if (!ok || get_byte(b0) !== 8'b0000_0011 || get_byte(b0 + NB) !== 8'b0001_0101) begin
            errors++; $display("FAIL b2b_bits: got %b %b expected 00000011 00010101", get_byte(b0), get_byte(b0 + NB));
        end
        checks++;
        if (busy_total - bz !== 2 * FRAME || done_total - dn !== 2) begin
            errors++; $display("FAIL b2b_counts: got busy %0d done %0d expected %0d 2", busy_total - bz, done_total - dn, 2 * FRAME);
        end
    endtask

    task automatic test_reset_shift();
        int b0, b1, dn;
        bit ok;
        b0 = bits_q.size();
        pulse_send(4'd4, 4'd5);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge CLK);
            #1;
            if (bits_q.size() >= b0 + 3) begin
                ok = 1'b1;
                break;
            end
        end
        RESET = 1'b1;
        #1;
        checks++;
        if (!ok || {TCLK, TDATA, TRESET, BUSY, DONE} !== 5'b0) begin
            errors++; $display("FAIL rst_shift_outputs: got %b reached %b expected 00000", {TCLK, TDATA, TRESET, BUSY, DONE}, ok);
        end
        @(negedge CLK);
        RESET = 1'b0;
        repeat (5) @(negedge CLK);
        checks++;
        if ({TCLK, TDATA, TRESET, BUSY, DONE} !== 5'b0) begin
            errors++; $display("FAIL rst_shift_idle: got %b expected 00000", {TCLK, TDATA, TRESET, BUSY, DONE});
        end
        b1 = bits_q.size(); dn = done_total;
        pulse_send(4'd1, 4'd2);
        wait_done(ok);
        checks++;
        if (!ok || get_byte(b1) !== 8'b0010_0001 || done_total - dn !== 1) begin
            errors++; $display("FAIL rst_shift_next: got %b done %0d expected 00100001 1", get_byte(b1), done_total - dn);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
`ifdef COLOR_SIZE_TX_PARITY_EN
        test_parity();
`endif
        test_busy_reject();
        test_back_to_back();
        test_reset_shift();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
